// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants: default 640x480@60 timing, totals and sync windows.
// Also a small window-compare helper used for the sync decodes.
package vga_timing_pkg;

    localparam int unsigned CntW = 12;

    localparam int unsigned HVisibleDflt = 640;
    localparam int unsigned HFrontDflt   = 16;
    localparam int unsigned HSyncDflt    = 96;
    localparam int unsigned HBackDflt    = 48;
    localparam int unsigned VVisibleDflt = 480;
    localparam int unsigned VFrontDflt   = 10;
    localparam int unsigned VSyncDflt    = 2;
    localparam int unsigned VBackDflt    = 33;

    localparam int unsigned HTotalDflt = HVisibleDflt + HFrontDflt + HSyncDflt + HBackDflt;
    localparam int unsigned VTotalDflt = VVisibleDflt + VFrontDflt + VSyncDflt + VBackDflt;

    localparam int unsigned HSyncStartDflt = HVisibleDflt + HFrontDflt;
    localparam int unsigned HSyncEndDflt   = HSyncStartDflt + HSyncDflt;
    localparam int unsigned VSyncStartDflt = VVisibleDflt + VFrontDflt;
    localparam int unsigned VSyncEndDflt   = VSyncStartDflt + VSyncDflt;

    // Half-open window [lo, hi), unsigned.
    function automatic logic in_window(input logic [CntW-1:0] cnt,
                                       input logic [CntW-1:0] lo,
                                       input logic [CntW-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay with asynchronous clear to a configurable value.
// Depth 0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int unsigned     Depth    = 0,
    parameter int unsigned     Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    if (Depth == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign q_o = d_i;
    end else begin : g_pipe
        logic [Depth-1:0][Width-1:0] stage_q, stage_d;

        always_comb begin
            stage_d[0] = d_i;
            for (int i = 1; i < Depth; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stage_q <= {Depth{ResetVal}};
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_o = stage_q[Depth-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, coordinate bus, aligned RGB/sync/blank
// outputs and per-line/per-frame strobes with a free-running frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE       = HVisibleDflt,
    parameter int unsigned H_FRONT         = HFrontDflt,
    parameter int unsigned H_SYNC          = HSyncDflt,
    parameter int unsigned H_BACK          = HBackDflt,
    parameter int unsigned V_VISIBLE       = VVisibleDflt,
    parameter int unsigned V_FRONT         = VFrontDflt,
    parameter int unsigned V_SYNC          = VSyncDflt,
    parameter int unsigned V_BACK          = VBackDflt,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned COLOR_LATENCY   = 0
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [2:0]  VGA_RGB,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        line_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (HTotal >= (1 << CntW) || VTotal >= (1 << CntW)) begin : g_bad_timing
        $error("vga_timing_gen: timing sums do not fit the 12-bit counters");
    end
    if (COLOR_LATENCY > 4) begin : g_bad_latency
        $error("vga_timing_gen: COLOR_LATENCY must be 0..4");
    end

    localparam logic [CntW-1:0] HLast = CntW'(HTotal - 1);
    localparam logic [CntW-1:0] VLast = CntW'(VTotal - 1);
    localparam logic [CntW-1:0] HVis  = CntW'(H_VISIBLE);
    localparam logic [CntW-1:0] VVis  = CntW'(V_VISIBLE);
    localparam logic [CntW-1:0] HsLo  = CntW'(H_VISIBLE + H_FRONT);
    localparam logic [CntW-1:0] HsHi  = CntW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CntW-1:0] VsLo  = CntW'(V_VISIBLE + V_FRONT);
    localparam logic [CntW-1:0] VsHi  = CntW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CntW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic            vis_d;
    logic            line_start_q, line_start_d, vblank_start_q, vblank_start_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [2:0]      rgb_q, rgb_d;
    logic            blank_n_q, blank_n_d, hs_q, hs_d, vs_q, vs_d;
    logic [2:0]      raw_s, dly_s;

    always_comb begin
        h_d = h_q + 12'd1;
        v_d = v_q;
        if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 12'd1;
        end
        // Coordinates track the state the counters move into, so x/y line up with h_q/v_q.
        vis_d          = (h_d < HVis) && (v_d < VVis);
        x_d            = vis_d ? h_d : '0;
        y_d            = vis_d ? v_d : '0;
        line_start_d   = (h_d == '0);
        vblank_start_d = line_start_d && (v_d == VVis);
        frame_count_d  = frame_count_q + {15'd0, vblank_start_d};
    end

    // {active, hs asserted, vs asserted} for the current counter state, before polarity.
    assign raw_s = {(h_q < HVis) && (v_q < VVis),
                    in_window(h_q, HsLo, HsHi),
                    in_window(v_q, VsLo, VsHi)};

    vga_delay_line #(
        .Depth   (COLOR_LATENCY),
        .Width   (3),
        .ResetVal(3'b000)
    ) u_align (
        .clk_i (CLOCK_25),
        .rst_ni(RESET_N),
        .d_i   (raw_s),
        .q_o   (dly_s)
    );

    always_comb begin
        rgb_d     = color & {3{dly_s[2]}};
        blank_n_d = dly_s[2];
        hs_d      = dly_s[1] ^ SYNC_ACTIVE_LOW;
        vs_d      = dly_s[0] ^ SYNC_ACTIVE_LOW;
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_q            <= '0;
            v_q            <= '0;
            x_q            <= '0;
            y_q            <= '0;
            line_start_q   <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= '0;
            rgb_q          <= '0;
            blank_n_q      <= 1'b0;
            hs_q           <= SYNC_ACTIVE_LOW;
            vs_q           <= SYNC_ACTIVE_LOW;
        end else begin
            h_q            <= h_d;
            v_q            <= v_d;
            x_q            <= x_d;
            y_q            <= y_d;
            line_start_q   <= line_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
            rgb_q          <= rgb_d;
            blank_n_q      <= blank_n_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign VGA_RGB      = rgb_q;
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_n_q;
    assign line_start   = line_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default raster (line timing), plus two small rasters
// (latency 0 active-low, latency 2 active-high) checked against an arithmetic raster model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 4;
    localparam int SVV = 8, SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;
    localparam int SFR = SHT * SVT;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [2:0]  rgb;
        logic        bn;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        vbs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] color_r = 3'd0, color_l = 3'd0;
    always #5 clk = ~clk;

    logic [11:0] x_f, y_f, x_s, y_s, x_l, y_l;
    logic [2:0]  rgb_f, rgb_s, rgb_l;
    logic        hs_f, vs_f, bn_f, ls_f, vbs_f;
    logic        hs_s, vs_s, bn_s, ls_s, vbs_s;
    logic        hs_l, vs_l, bn_l, ls_l, vbs_l;
    logic [15:0] fc_f, fc_s, fc_l;
    exp_t        act_f, act_s, act_l;

    assign act_f = {x_f, y_f, rgb_f, bn_f, hs_f, vs_f, ls_f, vbs_f, fc_f};
    assign act_s = {x_s, y_s, rgb_s, bn_s, hs_s, vs_s, ls_s, vbs_s, fc_s};
    assign act_l = {x_l, y_l, rgb_l, bn_l, hs_l, vs_l, ls_l, vbs_l, fc_l};

    vga_timing_gen u_dut_f (
        .CLOCK_25(clk), .RESET_N(rst_n), .color(color_r), .x(x_f), .y(y_f),
        .VGA_RGB(rgb_f), .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_BLANK_N(bn_f),
        .line_start(ls_f), .vblank_start(vbs_f), .frame_count(fc_f)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_ACTIVE_LOW(1'b1), .COLOR_LATENCY(0)
    ) u_dut_s (
        .CLOCK_25(clk), .RESET_N(rst_n), .color(color_r), .x(x_s), .y(y_s),
        .VGA_RGB(rgb_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bn_s),
        .line_start(ls_s), .vblank_start(vbs_s), .frame_count(fc_s)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_ACTIVE_LOW(1'b0), .COLOR_LATENCY(2)
    ) u_dut_l (
        .CLOCK_25(clk), .RESET_N(rst_n), .color(color_l), .x(x_l), .y(y_l),
        .VGA_RGB(rgb_l), .VGA_HS(hs_l), .VGA_VS(vs_l), .VGA_BLANK_N(bn_l),
        .line_start(ls_l), .vblank_start(vbs_l), .frame_count(fc_l)
    );

    int errors = 0;
    int checks = 0;
    int k = 0;  // rising edges since the last reset release
    bit const_color = 1'b0;
    logic [2:0] col_r_prev = 3'd0, col_l_prev = 3'd0, d1 = 3'd0, d2 = 3'd0;

    // Expected outputs k edges after release, from raster position arithmetic.
    function automatic exp_t model(input int kk, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int lat, input bit low,
                                   input logic [2:0] col);
        exp_t e;
        int ht, vt, h, v, j, hj, vj;
        bit vis;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        h = kk % ht;
        v = (kk / ht) % vt;
        vis = (h < hv) && (v < vv);
        e.x = vis ? 12'(h) : 12'd0;
        e.y = vis ? 12'(v) : 12'd0;
        j = kk - 1 - lat;
        if (j < 0) begin
            e.rgb = 3'd0; e.bn = 1'b0; e.hs = low; e.vs = low;
        end else begin
            hj = j % ht;
            vj = (j / ht) % vt;
            vis = (hj < hv) && (vj < vv);
            e.bn = vis;
            e.rgb = vis ? col : 3'd0;
            e.hs = ((hj >= hv + hf) && (hj < hv + hf + hsw)) ^ low;
            e.vs = ((vj >= vv + vf) && (vj < vv + vf + vsw)) ^ low;
        end
        e.ls = (kk >= 1) && (h == 0);
        e.vbs = (kk >= 1) && (h == 0) && (v == vv);
        e.fc = (kk >= vv * ht) ? 16'((kk - vv * ht) / (ht * vt) + 1) : 16'd0;
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("x=%0d y=%0d rgb=%b bn=%b hs=%b vs=%b ls=%b vbs=%b fc=%0d",
                         e.x, e.y, e.rgb, e.bn, e.hs, e.vs, e.ls, e.vbs, e.fc);
    endfunction

    // Advance one clock, then drive the image-generator side for the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        col_r_prev = color_r;
        col_l_prev = color_l;
        color_r = const_color ? 3'b101 : 3'($urandom);
        color_l = d2;  // x[2:0] two clocks late
        d2 = d1;
        d1 = x_l[2:0];
    endtask

    task automatic test_reset();
        exp_t rlow, rhigh;
        rlow  = '{x: 12'd0, y: 12'd0, rgb: 3'd0, bn: 1'b0, hs: 1'b1, vs: 1'b1,
                  ls: 1'b0, vbs: 1'b0, fc: 16'd0};
        rhigh = rlow;
        rhigh.hs = 1'b0;
        rhigh.vs = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks += 3;
            if (act_f !== rlow) begin
                errors++; $display("FAIL reset_f got %s exp %s", fmt(act_f), fmt(rlow));
            end
            if (act_s !== rlow) begin
                errors++; $display("FAIL reset_s got %s exp %s", fmt(act_s), fmt(rlow));
            end
            if (act_l !== rhigh) begin
                errors++; $display("FAIL reset_l got %s exp %s", fmt(act_l), fmt(rhigh));
            end
        end
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic test_frame_timing();
        int n = 0, last = -1, vs_low = 0;
        for (int c = 0; c < 1400 && n < 3; c++) begin
            tick();
            if (k <= SFR && vs_s == 1'b0) vs_low++;
            if (vbs_s) begin
                n++;
                checks++;
                if (fc_s !== 16'(n)) begin
                    errors++; $display("FAIL frame_count got %0d exp %0d", fc_s, n);
                end
                checks++;
                if (last < 0 && k != SVV * SHT) begin
                    errors++; $display("FAIL first_vblank got k=%0d exp %0d", k, SVV * SHT);
                end else if (last >= 0 && k - last != SFR) begin
                    errors++; $display("FAIL vblank_period got %0d exp %0d", k - last, SFR);
                end
                last = k;
            end
        end
        checks += 2;
        if (n != 3) begin
            errors++; $display("FAIL vblank_count got %0d exp 3", n);
        end
        if (vs_low != SVS * SHT) begin
            errors++; $display("FAIL vs_low_len got %0d exp %0d", vs_low, SVS * SHT);
        end
    endtask

    task automatic test_line_timing();
        int w, per = 0, hs_first = -1, hs_len = 0, bl_run = 0, bl_max = 0;
        for (w = 0; w < 1000 && !ls_f; w++) tick();
        checks++;
        if (!ls_f) begin
            errors++; $display("FAIL line_start_wait got none exp pulse");
            return;
        end
        for (int c = 1; c <= 1000; c++) begin
            tick();
            if (!hs_f) begin
                if (hs_first < 0) hs_first = c;
                hs_len++;
            end
            if (bn_f) begin
                bl_run++;
                if (bl_run > bl_max) bl_max = bl_run;
            end else begin
                bl_run = 0;
            end
            if (ls_f) begin
                per = c;
                break;
            end
        end
        checks += 4;
        if (per != int'(HTotalDflt)) begin
            errors++; $display("FAIL line_period got %0d exp %0d", per, HTotalDflt);
        end
        if (hs_first != int'(HSyncStartDflt) + 1) begin
            errors++; $display("FAIL hs_start got %0d exp %0d", hs_first, HSyncStartDflt + 1);
        end
        if (hs_len != int'(HSyncEndDflt - HSyncStartDflt)) begin
            errors++; $display("FAIL hs_len got %0d exp %0d", hs_len, HSyncDflt);
        end
        if (bl_max != int'(HVisibleDflt)) begin
            errors++; $display("FAIL blank_n_run got %0d exp %0d", bl_max, HVisibleDflt);
        end
    endtask

    task automatic test_color_gating();
        exp_t ef, es;
        const_color = 1'b1;
        tick();
        for (int c = 0; c < 900; c++) begin
            tick();
            ef = model(k, HVisibleDflt, HFrontDflt, HSyncDflt, HBackDflt, VVisibleDflt,
                       VFrontDflt, VSyncDflt, VBackDflt, 0, 1'b1, 3'b101);
            es = model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 0, 1'b1, 3'b101);
            checks += 4;
            if ({bn_f, rgb_f} !== {ef.bn, ef.rgb}) begin
                errors++; $display("FAIL gate_f k=%0d got bn=%b rgb=%b exp bn=%b rgb=%b",
                                   k, bn_f, rgb_f, ef.bn, ef.rgb);
            end
            if ({bn_s, rgb_s} !== {es.bn, es.rgb}) begin
                errors++; $display("FAIL gate_s k=%0d got bn=%b rgb=%b exp bn=%b rgb=%b",
                                   k, bn_s, rgb_s, es.bn, es.rgb);
            end
            if (x_f > 12'd639 || y_f > 12'd479) begin
                errors++; $display("FAIL xy_range_f got x=%0d y=%0d exp <=639,<=479", x_f, y_f);
            end
            if (x_s >= 12'(SHV) || y_s >= 12'(SVV)) begin
                errors++; $display("FAIL xy_range_s got x=%0d y=%0d exp <%0d,<%0d",
                                   x_s, y_s, SHV, SVV);
            end
        end
        const_color = 1'b0;
    endtask

    task automatic test_latency();
        int j, hj, vj;
        bit vis;
        for (int c = 0; c < 900; c++) begin
            tick();
            j = k - 3;
            hj = j % SHT;
            vj = (j / SHT) % SVT;
            vis = (hj < SHV) && (vj < SVV);
            checks++;
            if (bn_l !== vis) begin
                errors++; $display("FAIL lat_blank k=%0d got %b exp %b", k, bn_l, vis);
            end
            if (vis) begin
                checks++;
                if (rgb_l !== 3'(hj)) begin
                    errors++; $display("FAIL lat_rgb k=%0d got %b exp %b", k, rgb_l, 3'(hj));
                end
            end
            if (vis && hj == 0) begin
                checks++;
                if (rgb_l !== 3'b000) begin
                    errors++; $display("FAIL lat_first_pixel k=%0d got %b exp 000", k, rgb_l);
                end
            end
        end
    endtask

    task automatic test_random_model(input int n);
        exp_t ef, es, el;
        for (int c = 0; c < n; c++) begin
            tick();
            ef = model(k, HVisibleDflt, HFrontDflt, HSyncDflt, HBackDflt, VVisibleDflt,
                       VFrontDflt, VSyncDflt, VBackDflt, 0, 1'b1, col_r_prev);
            es = model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 0, 1'b1, col_r_prev);
            el = model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 2, 1'b0, col_l_prev);
            checks += 3;
            if (act_f !== ef) begin
                errors++; $display("FAIL model_f k=%0d got %s exp %s", k, fmt(act_f), fmt(ef));
            end
            if (act_s !== es) begin
                errors++; $display("FAIL model_s k=%0d got %s exp %s", k, fmt(act_s), fmt(es));
            end
            if (act_l !== el) begin
                errors++; $display("FAIL model_l k=%0d got %s exp %s", k, fmt(act_l), fmt(el));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int target, w;
        exp_t rlow, rhigh;
        rlow  = '{x: 12'd0, y: 12'd0, rgb: 3'd0, bn: 1'b0, hs: 1'b1, vs: 1'b1,
                  ls: 1'b0, vbs: 1'b0, fc: 16'd0};
        rhigh = rlow;
        rhigh.hs = 1'b0;
        rhigh.vs = 1'b0;
        target = int'($urandom_range(SVV - 2, 1)) * SHT + int'($urandom_range(SHV - 2, 1));
        for (w = 0; w < SFR && (k % SFR) != target; w++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (act_f !== rlow) begin
            errors++; $display("FAIL async_reset_f got %s exp %s", fmt(act_f), fmt(rlow));
        end
        if (act_s !== rlow) begin
            errors++; $display("FAIL async_reset_s got %s exp %s", fmt(act_s), fmt(rlow));
        end
        if (act_l !== rhigh) begin
            errors++; $display("FAIL async_reset_l got %s exp %s", fmt(act_l), fmt(rhigh));
        end
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        k = 0;
        for (w = 0; w < 2 * SHT && !ls_s; w++) tick();
        checks += 2;
        if (k != SHT) begin
            errors++; $display("FAIL restart_line_s got k=%0d exp %0d", k, SHT);
        end
        if (fc_s !== 16'd0) begin
            errors++; $display("FAIL restart_fc_s got %0d exp 0", fc_s);
        end
        for (w = 0; w < 1000 && !ls_f; w++) tick();
        checks += 2;
        if (k != int'(HTotalDflt)) begin
            errors++; $display("FAIL restart_line_f got k=%0d exp %0d", k, HTotalDflt);
        end
        if (fc_f !== 16'd0) begin
            errors++; $display("FAIL restart_fc_f got %0d exp 0", fc_f);
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_line_timing();
        test_color_gating();
        test_latency();
        test_random_model(1000);
        test_reset_mid_frame();
        test_random_model(600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
